// File: rtl/mainfsm.sv
// Main decoder FSM for the multicycle MIPS core: sequences fetch, decode and
// the per-instruction execute/writeback steps of the shared datapath.
module mainfsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    output logic       memwrite,
    output logic       lord,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsrc,
    output logic       branch,
    output logic       pcwrite,
    output logic       pcen,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    typedef struct packed {
        logic       memwrite;
        logic       lord;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       branch;
        logic       pcwrite;
    } ctrl_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t state_r;
    state_t next_state_s;
    ctrl_t  ctrl_r;

    // Moore output table; the register below loads the entry for the state
    // being entered so outputs stay a pure function of the current state.
    function automatic ctrl_t ctrl_for(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.alusrcb = 2'b01;
                c.irwrite = 1'b1;
                c.pcwrite = 1'b1;
            end
            DECODE:  c.alusrcb = 2'b11;
            MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            MEMRD:   c.lord = 1'b1;
            MEMWB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            MEMWR: begin
                c.lord     = 1'b1;
                c.memwrite = 1'b1;
            end
            RTYPEEX: begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b10;
            end
            RTYPEWB: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
            end
            BEQEX: begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b01;
                c.pcsrc   = 2'b01;
                c.branch  = 1'b1;
            end
            ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            ADDIWB:  c.regwrite = 1'b1;
            JEX: begin
                c.pcsrc   = 2'b10;
                c.pcwrite = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Next-state logic; unknown opcodes and illegal codes fall back to FETCH.
    always_comb begin
        next_state_s = FETCH;
        case (state_r)
            FETCH:  next_state_s = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state_s = MEMADR;
                    OP_RTYPE:     next_state_s = RTYPEEX;
                    OP_BEQ:       next_state_s = BEQEX;
                    OP_ADDI:      next_state_s = ADDIEX;
                    OP_J:         next_state_s = JEX;
                    default:      next_state_s = FETCH;
                endcase
            end
            MEMADR: begin
                if (op == OP_LW) begin
                    next_state_s = MEMRD;
                end else if (op == OP_SW) begin
                    next_state_s = MEMWR;
                end else begin
                    next_state_s = FETCH;
                end
            end
            MEMRD:   next_state_s = MEMWB;
            RTYPEEX: next_state_s = RTYPEWB;
            ADDIEX:  next_state_s = ADDIWB;
            default: next_state_s = FETCH;
        endcase
    end

    // State and control registers; reset lands directly on the FETCH outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= FETCH;
            ctrl_r  <= ctrl_for(FETCH);
        end else begin
            state_r <= next_state_s;
            ctrl_r  <= ctrl_for(next_state_s);
        end
    end

    assign memwrite = ctrl_r.memwrite;
    assign lord     = ctrl_r.lord;
    assign irwrite  = ctrl_r.irwrite;
    assign regdst   = ctrl_r.regdst;
    assign memtoreg = ctrl_r.memtoreg;
    assign regwrite = ctrl_r.regwrite;
    assign alusrca  = ctrl_r.alusrca;
    assign alusrcb  = ctrl_r.alusrcb;
    assign aluop    = ctrl_r.aluop;
    assign pcsrc    = ctrl_r.pcsrc;
    assign branch   = ctrl_r.branch;
    assign pcwrite  = ctrl_r.pcwrite;
    // The branch decision is the only place zero reaches an output.
    assign pcen     = ctrl_r.pcwrite | (ctrl_r.branch & zero);
    assign state    = state_r;

endmodule

// File: tb/tb_mainfsm.sv
// Scoreboard bench for mainfsm: stimulus pushes expected per-cycle state and
// control vectors, a negedge monitor pops and compares them.
module tb_mainfsm;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic       zero;
    logic       memwrite, lord, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, aluop, pcsrc;
    logic       branch, pcwrite, pcen;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0]  st;
        logic [15:0] ctl;
    } exp_t;

    exp_t sb_q[$];

    mainfsm dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero),
        .memwrite(memwrite), .lord(lord), .irwrite(irwrite), .regdst(regdst),
        .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
        .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc), .branch(branch),
        .pcwrite(pcwrite), .pcen(pcen), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] pk(input logic mw, input logic ld, input logic irw,
                                       input logic rd, input logic mtr, input logic rw,
                                       input logic asa, input logic [1:0] asb,
                                       input logic [1:0] aop, input logic [1:0] psrc,
                                       input logic br, input logic pw, input logic pe);
        return {mw, ld, irw, rd, mtr, rw, asa, asb, aop, psrc, br, pw, pe};
    endfunction

    // Hand-written expected controls per state (pcen column written out).
    function automatic logic [15:0] exp_ctl(input logic [3:0] s, input logic z);
        case (s)
            4'd0:    return pk(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b1,1'b1);
            4'd1:    return pk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0,1'b0,1'b0);
            4'd2:    return pk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0,1'b0);
            4'd3:    return pk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0);
            4'd4:    return pk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0);
            4'd5:    return pk(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0);
            4'd6:    return pk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0,1'b0,1'b0);
            4'd7:    return pk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0);
            4'd8:    return pk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b1,1'b0,z);
            4'd9:    return pk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0,1'b0);
            4'd10:   return pk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0);
            4'd11:   return pk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,1'b0,1'b1,1'b1);
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] act_ctl();
        return {memwrite, lord, irwrite, regdst, memtoreg, regwrite, alusrca,
                alusrcb, aluop, pcsrc, branch, pcwrite, pcen};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: one expected entry per cycle while out of reset.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check($sformatf("state(exp %0d)", e.st), {12'h000, state}, {12'h000, e.st});
                check($sformatf("ctrl(st %0d)", e.st), act_ctl(), e.ctl);
            end
        end
    end

    // seq holds up to six expected state nibbles, most significant first.
    task automatic run_instr(input logic [5:0] o, input logic z, input int n,
                             input logic [23:0] seq);
        logic [3:0] s;
        op   = o;
        zero = z;
        for (int i = 0; i < n; i++) begin
            s = seq[23 - 4*i -: 4];
            sb_q.push_back('{st: s, ctl: exp_ctl(s, z)});
        end
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int budget;
        reset = 1'b1;
        op    = 6'b000000;
        zero  = 1'b0;
        #3;
        check("reset_state", {12'h000, state}, 16'h0000);
        check("reset_ctrl", act_ctl(), exp_ctl(4'd0, 1'b0));
        @(posedge clk);
        #1 reset = 1'b0;

        run_instr(6'b100011, 1'b1, 5, 24'h012340);  // lw
        run_instr(6'b101011, 1'b1, 4, 24'h012500);  // sw
        run_instr(6'b000000, 1'b1, 4, 24'h016700);  // R-type, zero has no effect
        run_instr(6'b000100, 1'b0, 3, 24'h018000);  // beq not taken
        run_instr(6'b000100, 1'b1, 3, 24'h018000);  // beq taken
        run_instr(6'b001000, 1'b1, 4, 24'h019A00);  // addi
        run_instr(6'b000010, 1'b0, 3, 24'h01B000);  // j
        run_instr(6'b111111, 1'b1, 2, 24'h010000);  // illegal opcode
        run_instr(6'b000000, 1'b0, 4, 24'h016700);  // back-to-back R-type

        // op changes away from lw/sw while in MEMADR: falls back to FETCH
        op   = 6'b100011;
        zero = 1'b0;
        sb_q.push_back('{st: 4'd0, ctl: exp_ctl(4'd0, 1'b0)});
        sb_q.push_back('{st: 4'd1, ctl: exp_ctl(4'd1, 1'b0)});
        sb_q.push_back('{st: 4'd2, ctl: exp_ctl(4'd2, 1'b0)});
        repeat (2) @(posedge clk);
        #1 op = 6'b000100;
        @(posedge clk);
        #1;
        run_instr(6'b000010, 1'b1, 3, 24'h01B000);  // j after the abandoned access

        // Asynchronous reset in the middle of MEMRD
        run_instr(6'b100011, 1'b0, 3, 24'h012000);
        check("pre_reset_memrd", {12'h000, state}, 16'h0003);
        #1 reset = 1'b1;
        #1;
        check("async_reset_state", {12'h000, state}, 16'h0000);
        check("async_reset_ctrl", act_ctl(), exp_ctl(4'd0, 1'b0));
        @(posedge clk);
        #1 reset = 1'b0;
        run_instr(6'b001000, 1'b0, 4, 24'h019A00);  // addi after reset

        budget = 0;
        while (sb_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        if (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mainfsm.md
Name: mainfsm

Overview:
- Moore main-decoder state machine for the multicycle MIPS core.
- Sequences the shared datapath (single memory port, ALU, register file, PC) through fetch, decode and per-instruction execute/writeback steps.
- Sits inside the core controller, alongside the ALU decoder, which consumes aluop.
- Supported instructions: lw, sw, R-type, beq, addi, j.

Parameters:
- none (opcode values and state encodings are fixed below)

Ports:
- clk  input  1  core clock, rising edge
- reset  input  1  asynchronous, active-high; forces state to FETCH
- op  input  6  instr[31:26] from the instruction register
- zero  input  1  ALU zero flag
- memwrite  output  1  memory write strobe
- lord  output  1  address select: 0=PC, 1=ALUOut
- irwrite  output  1  instruction register load
- regdst  output  1  write register select: 0=rt, 1=rd
- memtoreg  output  1  write data select: 0=ALUOut, 1=Data register
- regwrite  output  1  register file write enable
- alusrca  output  1  SrcA select: 0=PC, 1=A
- alusrcb  output  2  SrcB select: 00=B, 01=4, 10=SignImm, 11=SignImm<<2
- aluop  output  2  to ALU decoder: 00=add, 01=sub, 10=funct
- pcsrc  output  2  PC source: 00=ALUResult, 01=ALUOut, 10=jump target
- branch  output  1  branch step active
- pcwrite  output  1  unconditional PC write
- pcen  output  1  pcwrite | (branch & zero)
- state  output  4  current state, for test and debug

Behaviour:
- State register, 4 bits.
- Encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11.
- Codes 12-15 are illegal; next state is FETCH.
- Reset is asynchronous: state goes to FETCH immediately while reset=1, independent of clk. A reset mid-instruction abandons it with no further write strobes.
- All outputs are a combinational function of state only (Moore), except pcen, which also uses zero. There is no other path from op or zero to the outputs.
- Reset output values are the FETCH values.
- Transitions:
  - FETCH -> DECODE.
  - DECODE branches on op:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 (R-type) -> RTYPEEX
    - 000100 (beq) -> BEQEX
    - 001000 (addi) -> ADDIEX
    - 000010 (j) -> JEX
    - any other op -> FETCH (illegal opcode is skipped; PC was already incremented in FETCH)
  - MEMADR -> MEMRD if op=lw, MEMWR if op=sw, FETCH otherwise.
  - MEMRD -> MEMWB.
  - RTYPEEX -> RTYPEWB.
  - ADDIEX -> ADDIWB.
  - MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX -> FETCH.
- Per-state outputs. Every output not listed is 0.
  - FETCH: alusrcb=01, irwrite=1, pcwrite=1 (lord=0, alusrca=0, aluop=00, pcsrc=00).
  - DECODE: alusrcb=11.
  - MEMADR: alusrca=1, alusrcb=10.
  - MEMRD: lord=1.
  - MEMWB: memtoreg=1, regwrite=1.
  - MEMWR: lord=1, memwrite=1.
  - RTYPEEX: alusrca=1, aluop=10.
  - RTYPEWB: regdst=1, regwrite=1.
  - BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1.
  - ADDIEX: alusrca=1, alusrcb=10.
  - ADDIWB: regwrite=1.
  - JEX: pcsrc=10, pcwrite=1.
- Cycles per instruction, counting FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- pcen is high in FETCH, in JEX, and in BEQEX only when zero=1. zero toggling in any other state has no effect on pcen.
- At most one of irwrite, memwrite, regwrite is high in any state.

Test Plan:
- Reset: assert reset mid-MEMRD, no clock edge -> state=0 at once; irwrite=1, pcwrite=1, pcen=1, alusrcb=01, all other strobes 0.
- lw: op=100011 -> state sequence 0,1,2,3,4,0; memtoreg=1 and regwrite=1 only in state 4; lord=1 only in state 3.
- sw then R-type: op=101011 -> 0,1,2,5,0 with memwrite=1 only in state 5; op=000000 -> 0,1,6,7,0 with aluop=10 in state 6 and regdst=1, regwrite=1 in state 7.
- beq: op=000100 -> 0,1,8,0; in state 8 with zero=0, pcen=0; with zero=1, pcen=1 and pcsrc=01.
- addi and j: op=001000 -> 0,1,9,10,0 with alusrcb=10 in state 9 and regwrite=1, regdst=0 in state 10; op=000010 -> 0,1,11,0 with pcsrc=10, pcen=1 in state 11.
- Illegal opcode: op=111111 in DECODE -> next state 0; no regwrite or memwrite pulse at any point.
